// File: rtl/banked_mask_write_bit_ram.sv
// banked_mask_write_bit_ram: single-port synchronous RAM with a per-bit write mask,
// split into num_width_bank_p column slices x num_depth_bank_p row banks.
// Low address bits select the row bank, so consecutive words interleave across banks.
// Only the addressed row bank is enabled on an access.
// Optional feature macro: BANKED_MEM_WRITE_THROUGH_EN (a write also returns the merged word).
module banked_mask_write_bit_ram #(
  parameter int unsigned width_p           = 32,
  parameter int unsigned els_p             = 64,
  parameter int unsigned latch_last_read_p = 0,
  parameter int unsigned num_width_bank_p  = 1,
  parameter int unsigned num_depth_bank_p  = 1,
  localparam int unsigned addr_width_lp      = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned bank_idx_width_lp  = (num_depth_bank_p > 1) ? $clog2(num_depth_bank_p) : 1,
  localparam int unsigned bank_els_lp        = els_p / num_depth_bank_p,
  localparam int unsigned bank_addr_width_lp = (bank_els_lp > 1) ? $clog2(bank_els_lp) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,
  output logic [width_p-1:0]       data_o
);

  localparam int unsigned slice_width_lp = width_p / num_width_bank_p;
  localparam int unsigned idx_shift_lp   = (num_depth_bank_p > 1) ? bank_idx_width_lp : 0;

`ifdef BANKED_MEM_WRITE_THROUGH_EN
  localparam bit write_through_lp = 1'b1;
`else
  localparam bit write_through_lp = 1'b0;
`endif

  // Elaboration-time parameter sanity checks
  if ((num_width_bank_p == 0) || ((width_p % num_width_bank_p) != 0)) begin : g_chk_width
    $error("width_p must be a non-zero multiple of num_width_bank_p");
  end
  if ((num_depth_bank_p == 0) || ((els_p % num_depth_bank_p) != 0)) begin : g_chk_depth
    $error("els_p must be a non-zero multiple of num_depth_bank_p");
  end
  if ((num_depth_bank_p & (num_depth_bank_p - 1)) != 0) begin : g_chk_pow2
    $error("num_depth_bank_p must be a power of two");
  end

  logic                          in_range_c;
  logic                          acc_rd_c;
  logic [bank_idx_width_lp-1:0]  bank_idx_c;
  logic [bank_addr_width_lp-1:0] bank_addr_c;
  logic [num_depth_bank_p-1:0]   bank_en_c;
  logic                          out_v_q;
  logic [width_p-1:0]            sel_rd_c;

  wire  [width_p-1:0]            bank_rd [num_depth_bank_p];

  // Address split, access type and one-hot bank enable
  always_comb begin
    in_range_c  = (32'(addr_i) < els_p);
    acc_rd_c    = ~w_i | write_through_lp;
    bank_idx_c  = (num_depth_bank_p > 1) ? bank_idx_width_lp'(addr_i) : '0;
    bank_addr_c = bank_addr_width_lp'(addr_i >> idx_shift_lp);
    bank_en_c   = '0;
    for (int unsigned d = 0; d < num_depth_bank_p; d++) begin
      bank_en_c[d] = reset_n_i & v_i & in_range_c & (32'(bank_idx_c) == d);
    end
  end

  // Row banks, each made of independent column slices
  for (genvar d = 0; d < int'(num_depth_bank_p); d++) begin : g_bank
    for (genvar s = 0; s < int'(num_width_bank_p); s++) begin : g_slice
      logic [slice_width_lp-1:0] mem [bank_els_lp];
      logic [slice_width_lp-1:0] rd_q;
      logic [slice_width_lp-1:0] cur_c;
      logic [slice_width_lp-1:0] wd_c;
      logic [slice_width_lp-1:0] wm_c;
      logic [slice_width_lp-1:0] merged_c;

      // Bit-masked merge of write data onto the stored word
      always_comb begin
        wd_c     = data_i[s*slice_width_lp +: slice_width_lp];
        wm_c     = w_mask_i[s*slice_width_lp +: slice_width_lp];
        cur_c    = mem[bank_addr_c];
        merged_c = (cur_c & ~wm_c) | (wd_c & wm_c);
      end

      // Storage array and read register; contents are intentionally not reset
      always_ff @(posedge clk_i) begin
        if (bank_en_c[d]) begin
          if (w_i) begin
            mem[bank_addr_c] <= merged_c;
          end
          if (acc_rd_c) begin
            rd_q <= w_i ? merged_c : cur_c;
          end
        end
      end

      assign bank_rd[d][s*slice_width_lp +: slice_width_lp] = rd_q;
    end
  end

  // Output mux select: registered bank index, only present with several row banks
  if (num_depth_bank_p > 1) begin : g_sel
    logic [bank_idx_width_lp-1:0] sel_q;

    // Capture the bank index of each accepted read
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        sel_q <= '0;
      end else if (v_i && acc_rd_c && in_range_c) begin
        sel_q <= bank_idx_c;
      end
    end

    assign sel_rd_c = bank_rd[sel_q];
  end else begin : g_no_sel
    assign sel_rd_c = bank_rd[0];
  end

  // Output-valid flag: set by an in-range read, cleared or held on other cycles
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_q <= 1'b0;
    end else if (v_i && acc_rd_c) begin
      out_v_q <= in_range_c;
    end else if (latch_last_read_p == 0) begin
      out_v_q <= 1'b0;
    end
  end

  // Zero the output after reset, non-read cycles (no latching) and out-of-range reads
  always_comb begin
    data_o = '0;
    if (out_v_q) begin
      data_o = sel_rd_c;
    end
  end

endmodule

// File: tb/tb_banked_mask_write_bit_ram.sv
// Scoreboard bench for banked_mask_write_bit_ram (8 bits x 16 words, 2 slices x 4 banks).
// Two instances run the same stimulus: one without and one with output latching.
module tb_banked_mask_write_bit_ram;

`ifdef BANKED_MEM_WRITE_THROUGH_EN
  localparam bit wt = 1'b1;
`else
  localparam bit wt = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       v;
  logic       w;
  logic [3:0] addr;
  logic [7:0] data;
  logic [7:0] mask;
  logic [7:0] q0;
  logic [7:0] q1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tag   = 0;
  logic [7:0] last1;

  typedef struct {
    int         due;
    int         tag;
    logic [7:0] e0;
    logic [7:0] e1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  banked_mask_write_bit_ram #(
    .width_p(8), .els_p(16), .latch_last_read_p(0),
    .num_width_bank_p(2), .num_depth_bank_p(4)
  ) u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .w_i(w), .addr_i(addr),
    .data_i(data), .w_mask_i(mask), .data_o(q0)
  );

  banked_mask_write_bit_ram #(
    .width_p(8), .els_p(16), .latch_last_read_p(1),
    .num_width_bank_p(2), .num_depth_bank_p(4)
  ) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .w_i(w), .addr_i(addr),
    .data_i(data), .w_mask_i(mask), .data_o(q1)
  );

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare data_o of both instances against the entry due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due < cyc) begin
        total++;
        bad++;
        $display("FAIL op%0d stale: got due %0d expected %0d", mon_e.tag, mon_e.due, cyc);
      end else begin
        check($sformatf("op%0d nolatch", mon_e.tag), q0, mon_e.e0);
        check($sformatf("op%0d latch", mon_e.tag), q1, mon_e.e1);
      end
    end
  end

  // One access cycle; rdexp is the word value at addr after this access
  task automatic op(input logic vv, input logic ww, input logic [3:0] a,
                    input logic [7:0] d, input logic [7:0] m, input logic [7:0] rdexp);
    exp_t op_e;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    v = vv; w = ww; addr = a; data = d; mask = m;
    op_e.due = cyc + 1;
    op_e.tag = tag;
    tag++;
    if (vv && (!ww || wt)) begin
      op_e.e0 = rdexp;
      op_e.e1 = rdexp;
      last1   = rdexp;
    end else begin
      op_e.e0 = 8'h00;
      op_e.e1 = last1;
    end
    sb.push_back(op_e);
  endtask

  // Assert reset mid-cycle while a full write to addr 9 is presented
  task automatic mid_reset();
    exp_t op_e;
    @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    v = 1'b1; w = 1'b1; addr = 4'd9; data = 8'hFF; mask = 8'hFF;
    #1;
    check("async_reset nolatch", q0, 8'h00);
    check("async_reset latch", q1, 8'h00);
    last1    = 8'h00;
    op_e.due = cyc + 1;
    op_e.tag = tag;
    tag++;
    op_e.e0  = 8'h00;
    op_e.e1  = 8'h00;
    sb.push_back(op_e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    v = 1'b0; w = 1'b0; addr = '0; data = '0; mask = '0;
    last1 = 8'h00;
    #1 reset_n = 1'b0;
    #1;
    check("reset_state nolatch", q0, 8'h00);
    check("reset_state latch", q1, 8'h00);
    repeat (2) @(posedge clk);

    // Reset during a write must not corrupt the stored word
    op(1, 1, 4'd9, 8'h12, 8'hFF, 8'h12);
    op(1, 0, 4'd9, 8'h00, 8'h00, 8'h12);
    mid_reset();
    op(1, 0, 4'd9, 8'h00, 8'h00, 8'h12);

    // Full write then read
    op(1, 1, 4'd5, 8'hA5, 8'hFF, 8'hA5);
    op(1, 0, 4'd5, 8'h00, 8'h00, 8'hA5);
    // Partial mask and all-zero mask
    op(1, 1, 4'd5, 8'h00, 8'h0F, 8'hA0);
    op(1, 0, 4'd5, 8'h00, 8'h00, 8'hA0);
    op(1, 1, 4'd5, 8'hFF, 8'h00, 8'hA0);
    op(1, 0, 4'd5, 8'h00, 8'h00, 8'hA0);

    // Bank isolation: fill all words, read back descending, back-to-back
    for (int i = 0; i < 16; i++) op(1, 1, 4'(i), 8'(i * 17), 8'hFF, 8'(i * 17));
    for (int i = 15; i >= 0; i--) op(1, 0, 4'(i), 8'h00, 8'h00, 8'(i * 17));

    // Output hold over idle cycles
    op(1, 0, 4'd3, 8'h00, 8'h00, 8'h33);
    op(0, 0, 4'd3, 8'h00, 8'h00, 8'h00);
    op(0, 0, 4'd3, 8'h00, 8'h00, 8'h00);

    // Masked write onto 8'h77 (merged 8'h37), then verify neighbour untouched
    op(1, 1, 4'd7, 8'h3C, 8'hF0, 8'h37);
    op(0, 0, 4'd0, 8'h00, 8'h00, 8'h00);
    op(1, 0, 4'd7, 8'h00, 8'h00, 8'h37);
    op(1, 0, 4'd6, 8'h00, 8'h00, 8'h66);

    // w_i without v_i must not write
    op(0, 1, 4'd2, 8'h00, 8'hFF, 8'h00);
    op(1, 0, 4'd2, 8'h00, 8'h00, 8'h22);
    op(0, 0, 4'd0, 8'h00, 8'h00, 8'h00);
    op(0, 0, 4'd0, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banked_mask_write_bit_ram.md
Name: banked_mask_write_bit_ram

Overview:
- Single-port synchronous RAM with per-bit write mask.
- Internally split into num_width_bank_p column slices × num_depth_bank_p row banks.
- Only the addressed depth bank is enabled on each access, which saves power and lets the block map onto small SRAM macros.
- Used as a drop-in wide/deep memory in cache and buffer datapaths.

Parameters:
- width_p, 32, total word width; must be a multiple of num_width_bank_p.
- els_p, 64, total number of words; must be a multiple of num_depth_bank_p.
- latch_last_read_p, 0, 1 = data_o holds the last read value until the next read.
- num_width_bank_p, 1, number of column slices; each slice is width_p/num_width_bank_p bits wide.
- num_depth_bank_p, 1, number of row banks; must be a power of two. Each bank holds els_p/num_depth_bank_p words.
- Derived (not overridable):
  - addr_width_lp = clog2(els_p), minimum 1.
  - bank_idx_width_lp = clog2(num_depth_bank_p), minimum 1.
  - bank_addr_width_lp = clog2(els_p/num_depth_bank_p), minimum 1.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- reset_n_i, in, 1, asynchronous active-low reset.
- v_i, in, 1, access request this cycle.
- w_i, in, 1, 1 = write, 0 = read; qualified by v_i.
- addr_i, in, addr_width_lp, word address.
- data_i, in, width_p, write data.
- w_mask_i, in, width_p, per-bit write enable; 1 = write that bit.
- data_o, out, width_p, read data; valid the cycle after a read.

Behaviour:
- Address split:
  - Bank index = addr_i[bank_idx_width_lp-1:0], i.e. the low bits, so consecutive words interleave across banks.
  - Bank address = addr_i[bank_idx_width_lp +: bank_addr_width_lp].
  - If num_depth_bank_p=1: there is no index, the full addr_i is the bank address, and no index register exists.
- Bank enable: one-hot decode of the bank index, gated by v_i. Only the selected depth bank (all its width slices) is active. Unselected banks neither read nor write.
- Write (v_i=1, w_i=1):
  - For every bit b with w_mask_i[b]=1, mem[addr][b] <= data_i[b] at the rising edge.
  - Bits with mask 0 keep their value.
  - An all-zero mask is a legal no-op.
- Read (v_i=1, w_i=0):
  - The word at addr_i appears on data_o in the next cycle (latency 1).
  - The bank index is captured into an enable-flop (enable = v_i & ~w_i) that drives the output mux select.
- Idle cycles and write cycles:
  - latch_last_read_p=1: data_o keeps the last read value.
  - latch_last_read_p=0: data_o = 0 in the cycle after any non-read cycle.
- Reset:
  - Asserting reset_n_i low asynchronously clears the bank-index register and the output/hold registers, so data_o = 0.
  - Memory array contents are not reset; they remain undefined until written.
  - While reset is low, v_i is ignored and no write occurs.
  - The first access is accepted on the first rising edge after deassertion.
- Read after write to the same address: the next read returns the merged value.
- Back-to-back reads to different banks: each cycle's data_o reflects the previous cycle's read; the mux select updates every read.
- Out-of-range address (addr_i >= els_p): writes are dropped and reads return 0.
- Elaboration-time check: an error is raised if the divisibility or power-of-two constraints are violated.

Optional Feature:
- Macro: BANKED_MEM_WRITE_THROUGH_EN.
- Defined: a write cycle also acts as a read. The next cycle data_o shows the post-write merged word at addr_i, and the bank-index register is also enabled on writes.
- Undefined: write cycles do not update data_o, which follows the latch_last_read_p rule above.

Test Plan:
All scenarios use width_p=8, els_p=16, num_width_bank_p=2, num_depth_bank_p=4.
- Reset: hold reset_n_i low mid-run with v_i=1, w_i=1, data_i=8'hFF → data_o=0 immediately; after release, a read of that address does not return 8'hFF unless it was written before reset.
- Full write then read: write addr 5 with data 8'hA5, mask 8'hFF, then read addr 5 → data_o=8'hA5 one cycle later.
- Partial mask: write addr 5 with data 8'h00, mask 8'h0F, then read → 8'hA0; write addr 5 with data 8'hFF, mask 8'h00, then read → 8'hA0.
- Bank isolation: write addr 0..15 with data=addr*17 (low 8 bits), then read 15 down to 0 back-to-back → each value appears one cycle after its read and no other address is disturbed.
- Output hold: read addr 3, then idle two cycles:
  - latch_last_read_p=1 → data_o stays 8'h33.
  - latch_last_read_p=0 → data_o=0 in the idle cycles.
- With BANKED_MEM_WRITE_THROUGH_EN: write addr 7 with data 8'h3C, mask 8'hF0, onto prior content 8'h77 → next-cycle data_o=8'h37.
